// File: rtl/mm_ascii_frame_tx.sv
// Streams a latched N-digit BCD value as a fixed-length ASCII frame: sign, digits, optional '.', CR.
// Define MM_ASCII_LF_EN to append an LF byte after CR.
module mm_ascii_frame_tx #(
    parameter int N_DIGITS = 4,
    parameter int DP_POS   = 3,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [4*N_DIGITS-1:0] bcd_i,
    input  logic                  neg_i,
    output logic                  busy_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  done_o
);

    localparam int W  = 4 * N_DIGITS;
    localparam int IW = $clog2(N_DIGITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] DP_IDX   = IW'(N_DIGITS - DP_POS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGN,
        S_DIGIT,
        S_DP,
        S_CR
`ifdef MM_ASCII_LF_EN
        , S_LF
`endif
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  bcd_q;
    logic          neg_q;
    logic [IW-1:0] idx;
    logic          lead;
    logic [3:0]    nib;
    logic          xfer;
    logic          accept;
    logic          blank;
    logic          last_byte;

    // bcd_q shifts left per digit, so the digit being sent is always the top nibble
    assign nib    = bcd_q[W-1 -: 4];
    assign xfer   = tx_valid_o & tx_ready_i;
    assign accept = start_i & (state == S_IDLE);
    // only digits strictly left of the DP-adjacent (or LS) digit may be blanked
    assign blank  = (LZ_BLANK != 0) && lead && (nib == 4'h0) && (idx < DP_IDX);

`ifdef MM_ASCII_LF_EN
    assign last_byte = (state == S_LF);
`else
    assign last_byte = (state == S_CR);
`endif

    assign busy_o     = (state != S_IDLE);
    assign tx_valid_o = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tx_data_o = '0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nx = S_SIGN;
            end
            S_SIGN: begin
                tx_data_o = neg_q ? 8'h2D : 8'h2B;
                if (xfer) state_nx = S_DIGIT;
            end
            S_DIGIT: begin
                if (blank)            tx_data_o = 8'h20;
                else if (nib <= 4'd9) tx_data_o = {4'h3, nib};
                else                  tx_data_o = 8'h3F;
                if (xfer) begin
                    if (idx == LAST_IDX)                    state_nx = S_CR;
                    else if (DP_POS != 0 && idx == DP_IDX)  state_nx = S_DP;
                end
            end
            S_DP: begin
                tx_data_o = 8'h2E;
                if (xfer) state_nx = S_DIGIT;
            end
            S_CR: begin
                tx_data_o = 8'h0D;
`ifdef MM_ASCII_LF_EN
                if (xfer) state_nx = S_LF;
`else
                if (xfer) state_nx = S_IDLE;
`endif
            end
`ifdef MM_ASCII_LF_EN
            S_LF: begin
                tx_data_o = 8'h0A;
                if (xfer) state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            neg_q  <= 1'b0;
            idx    <= '0;
            lead   <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= xfer & last_byte;
            if (accept) begin
                bcd_q <= bcd_i;
                neg_q <= neg_i;
                idx   <= '0;
                lead  <= 1'b1;
            end else if (state == S_DIGIT && xfer) begin
                bcd_q <= bcd_q << 4;
                lead  <= blank;
                if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mm_ascii_frame_tx.sv
// Scoreboard bench for mm_ascii_frame_tx: a default instance (DP_POS=3) and a DP_POS=0 instance.
// Expected frames come from an independent byte model and are popped as bytes transfer.
module tb_mm_ascii_frame_tx;

`ifdef MM_ASCII_LF_EN
    localparam int LEN0 = 8;
    localparam int LEN1 = 7;
`else
    localparam int LEN0 = 7;
    localparam int LEN1 = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] neg = '0;
    logic [1:0] tx_ready = '0;
    logic [1:0] busy, tx_valid, done;
    logic [15:0] bcd [2];
    logic [7:0]  tx_data [2];

    always #5 clk = ~clk;

    mm_ascii_frame_tx #(.N_DIGITS(4), .DP_POS(3), .LZ_BLANK(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .bcd_i(bcd[0]), .neg_i(neg[0]),
        .busy_o(busy[0]), .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]),
        .tx_ready_i(tx_ready[0]), .done_o(done[0])
    );

    mm_ascii_frame_tx #(.N_DIGITS(4), .DP_POS(0), .LZ_BLANK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .bcd_i(bcd[1]), .neg_i(neg[1]),
        .busy_o(busy[1]), .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]),
        .tx_ready_i(tx_ready[1]), .done_o(done[1])
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;

    bit         done_pend [2];
    bit         stall_prev [2];
    logic [7:0] stall_data [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input int d, input logic [15:0] v, input logic s);
        exp_t       frm[$];
        exp_t       e;
        logic [3:0] nib;
        bit         lead = 1'b1;
        int         dp = (d == 0) ? 3 : 0;
        e.last = 1'b0;
        e.b = s ? 8'h2D : 8'h2B;
        frm.push_back(e);
        for (int i = 0; i < 4; i++) begin
            nib = v[15-4*i -: 4];
            if (lead && nib == 4'h0 && i < 3 - dp) begin
                e.b = 8'h20;
            end else begin
                lead = 1'b0;
                e.b = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : 8'h3F;
            end
            frm.push_back(e);
            if (dp > 0 && i == 3 - dp) begin
                e.b = 8'h2E;
                frm.push_back(e);
            end
        end
        e.b = 8'h0D;
        frm.push_back(e);
`ifdef MM_ASCII_LF_EN
        e.b = 8'h0A;
        frm.push_back(e);
`endif
        frm[frm.size()-1].last = 1'b1;
        foreach (frm[k]) begin
            if (d == 0) q0.push_back(frm[k]);
            else        q1.push_back(frm[k]);
        end
    endfunction

    task automatic monitor(input int d);
        exp_t e;
        bit   pend = 1'b0;
        bit   empty;
        if (!rst_n) begin
            done_pend[d]  = 1'b0;
            stall_prev[d] = 1'b0;
            return;
        end
        check($sformatf("done%0d", d), done[d], done_pend[d]);
        if (stall_prev[d]) begin
            check($sformatf("hold_valid%0d", d), tx_valid[d], 1);
            check($sformatf("hold_data%0d", d), tx_data[d], stall_data[d]);
        end
        if (tx_valid[d] && tx_ready[d]) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check($sformatf("unexpected_byte%0d", d), tx_valid[d], 0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("byte%0d", d), tx_data[d], e.b);
                pend = e.last;
            end
        end
        stall_prev[d] = tx_valid[d] && !tx_ready[d];
        stall_data[d] = tx_data[d];
        done_pend[d]  = pend;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor(d);
    end

    // call away from a rising edge while the instance is idle (or in its done cycle)
    task automatic start_frame(input int d, input logic [15:0] v, input logic s);
        bcd[d]   = v;
        neg[d]   = s;
        start[d] = 1'b1;
        push_frame(d, v, s);
        @(posedge clk);
        #1 start[d] = 1'b0;
        check("accept_valid", tx_valid[d], 1);
        check("accept_busy", busy[d], 1);
        check("accept_sign", tx_data[d], s ? 8'h2D : 8'h2B);
    endtask

    task automatic wait_done(input int d, input bit rnd, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk);
            #1 if (rnd) tx_ready[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (done[d]) seen = 1'b1;
        end
        if (!seen) check("done_timeout", done[d], 1);
        else       check("done_idle_busy", busy[d], 0);
    endtask

    int cyc;

    initial begin
        bcd[0] = '0;
        bcd[1] = '0;
        tx_ready = 2'b11;
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", tx_valid[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_data", tx_data[d], 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        start_frame(0, 16'h0123, 1'b0);
        wait_done(0, 1'b0, cyc);
        check("t1_cycles", cyc, LEN0);
        // restart in the done cycle
        start_frame(0, 16'h1234, 1'b1);
        wait_done(0, 1'b0, cyc);
        check("t2_cycles", cyc, LEN0);

        @(negedge clk);
        start_frame(1, 16'h0042, 1'b0);
        wait_done(1, 1'b0, cyc);
        check("dp0_cycles", cyc, LEN1);
        @(negedge clk);
        start_frame(1, 16'h0000, 1'b0);
        wait_done(1, 1'b0, cyc);

        @(negedge clk);
        start_frame(0, 16'h1A23, 1'b0);
        wait_done(0, 1'b0, cyc);

        // stall five cycles on the '.' byte
        @(negedge clk);
        start_frame(0, 16'h0123, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 tx_ready[0] = 1'b0;
        check("stall_data", tx_data[0], 8'h2E);
        repeat (5) @(posedge clk);
        #1 tx_ready[0] = 1'b1;
        wait_done(0, 1'b0, cyc);
        check("stall_cycles", cyc, LEN0 - 2);

        // start pulse mid-frame must be ignored
        @(negedge clk);
        start_frame(0, 16'h0987, 1'b1);
        @(posedge clk);
        #1 begin
            bcd[0]   = 16'h5555;
            neg[0]   = 1'b0;
            start[0] = 1'b1;
        end
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 1'b0, cyc);
        check("busy_start_cycles", cyc, LEN0 - 2);

        // asynchronous reset while the fourth byte is presented
        @(negedge clk);
        start_frame(0, 16'h0456, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", tx_valid[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_done", done[0], 0);
        check("midrst_data", tx_data[0], 0);
        q0.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start_frame(0, 16'h0789, 1'b0);
        wait_done(0, 1'b0, cyc);
        check("postrst_cycles", cyc, LEN0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_frame(i % 2, 16'($urandom), 1'($urandom_range(0, 1)));
            wait_done(i % 2, 1'b1, cyc);
            tx_ready = 2'b11;
        end

        @(negedge clk);
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
